// File: rtl/regfile_seq_ctrl.sv
// Command sequencer for the 16x8 register file: loads the operand-pointer register
// only when its shadow copy is stale, then issues one register file action per command.
module regfile_seq_ctrl #(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int OPS_IDX = 13
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         CmdValid,
    output logic         CmdReady,
    input  logic [2:0]   CmdOp,
    input  logic [D-1:0] CmdRa,
    input  logic [D-1:0] CmdRb,
    input  logic [W-1:0] CmdData,
    output logic         Done,
    output logic         Busy,
    output logic         OpsWrite,
    output logic         LoadHigh,
    output logic         Jmp,
    output logic         IsMov,
    output logic         LoadByte,
    output logic [D-1:0] Waddr,
    output logic [D-1:0] JmpReg,
    output logic [W-1:0] RfDataIn
);

    typedef enum logic [1:0] {S_IDLE, S_SET_HI, S_SET_LO, S_EXEC} state_t;

    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_MOV    = 3'd2;
    localparam logic [2:0] OP_LOADB  = 3'd3;
    localparam logic [2:0] OP_READ   = 3'd4;
    localparam logic [2:0] OP_JMP    = 3'd5;
    localparam logic [2:0] OP_SETPTR = 3'd6;
    localparam logic [D-1:0] OPS     = D'(OPS_IDX);

    state_t         state_q, state_d;
    logic           run_q, run_d;
    logic [2:0]     op_q, op_d;
    logic [D-1:0]   ra_q, ra_d, rb_q, rb_d;
    logic [W-1:0]   data_q, data_d;
    logic           need_lo_q, need_lo_d;
    logic [D-1:0]   ptr_hi_q, ptr_hi_d, ptr_lo_q, ptr_lo_d;
    logic           hi_valid_q, hi_valid_d, lo_valid_q, lo_valid_d;
    logic           accept, need_hi, need_lo;

    // run_q keeps CmdReady low for the cycle in which reset is being applied
    assign accept  = (state_q == S_IDLE) && run_q && CmdValid;
    assign need_hi = (CmdOp == OP_SETPTR) ||
                     (((CmdOp == OP_MOV) || (CmdOp == OP_READ)) &&
                      !(hi_valid_q && (ptr_hi_q == CmdRa)));
    assign need_lo = (CmdOp == OP_SETPTR) ||
                     (((CmdOp == OP_LOADB) || (CmdOp == OP_READ)) &&
                      !(lo_valid_q && (ptr_lo_q == CmdRb)));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            run_q      <= 1'b0;
            op_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            data_q     <= '0;
            need_lo_q  <= 1'b0;
            ptr_hi_q   <= '0;
            ptr_lo_q   <= '0;
            hi_valid_q <= 1'b0;
            lo_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            op_q       <= op_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            data_q     <= data_d;
            need_lo_q  <= need_lo_d;
            ptr_hi_q   <= ptr_hi_d;
            ptr_lo_q   <= ptr_lo_d;
            hi_valid_q <= hi_valid_d;
            lo_valid_q <= lo_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        op_d       = op_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        data_d     = data_q;
        need_lo_d  = need_lo_q;
        ptr_hi_d   = ptr_hi_q;
        ptr_lo_d   = ptr_lo_q;
        hi_valid_d = hi_valid_q;
        lo_valid_d = lo_valid_q;
        // Idle encoding: Jmp alone stops the register file from writing Waddr/r12
        CmdReady   = 1'b0;
        Done       = 1'b0;
        Busy       = (state_q != S_IDLE);
        OpsWrite   = 1'b0;
        LoadHigh   = 1'b0;
        Jmp        = 1'b1;
        IsMov      = 1'b0;
        LoadByte   = 1'b0;
        Waddr      = '0;
        JmpReg     = '0;
        RfDataIn   = '0;

        case (state_q)
            S_IDLE: begin
                CmdReady = run_q;
                if (accept) begin
                    op_d      = CmdOp;
                    ra_d      = CmdRa;
                    rb_d      = CmdRb;
                    data_d    = CmdData;
                    need_lo_d = need_lo;
                    if (need_hi)      state_d = S_SET_HI;
                    else if (need_lo) state_d = S_SET_LO;
                    else              state_d = S_EXEC;
                end
            end
            S_SET_HI: begin
                OpsWrite   = 1'b1;
                LoadHigh   = 1'b1;
                Jmp        = 1'b0;
                RfDataIn   = {{(W-D){1'b0}}, ra_q};
                ptr_hi_d   = ra_q;
                hi_valid_d = 1'b1;
                state_d    = need_lo_q ? S_SET_LO : S_EXEC;
            end
            S_SET_LO: begin
                OpsWrite   = 1'b1;
                Jmp        = 1'b0;
                RfDataIn   = {{(W-D){1'b0}}, rb_q};
                ptr_lo_d   = rb_q;
                lo_valid_d = 1'b1;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                Done    = 1'b1;
                state_d = S_IDLE;
                case (op_q)
                    OP_WRITE: begin
                        Jmp      = 1'b0;
                        Waddr    = ra_q;
                        RfDataIn = data_q;
                    end
                    OP_MOV: begin
                        Jmp      = 1'b0;
                        IsMov    = 1'b1;
                        RfDataIn = data_q;
                    end
                    OP_LOADB: begin
                        Jmp      = 1'b0;
                        LoadByte = 1'b1;
                        RfDataIn = data_q;
                    end
                    OP_READ: begin
                        // Harmless rewrite of r13 with its current high nibble
                        Jmp      = 1'b0;
                        OpsWrite = 1'b1;
                        LoadHigh = 1'b1;
                        RfDataIn = {{(W-D){1'b0}}, ptr_hi_q};
                    end
                    OP_JMP: JmpReg = ra_q;
                    default: ;
                endcase
                if (((op_q == OP_WRITE) && (ra_q == OPS)) ||
                    ((op_q == OP_MOV)   && (ptr_hi_q == OPS)) ||
                    ((op_q == OP_LOADB) && (ptr_lo_q == OPS))) begin
                    hi_valid_d = 1'b0;
                    lo_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
